// File: rtl/alu_result_uart_tx.sv
// Snapshots the ALU result and flags on a send request and shifts them out
// as two back-to-back 8N1 UART frames: result byte, then {00000,V,C,Z}.
module alu_result_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [7:0] result,
  input  logic       zero,
  input  logic       carry,
  input  logic       overflow,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int            BW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic          r_sel, w_sel_nxt;
  logic [7:0]    r_byte0, r_byte1;
  logic [7:0]    w_cur_byte;
  logic          w_cap, w_tick, w_tx_nxt, w_done_nxt;
  logic          r_tx, r_busy, r_done;

  assign w_tick     = (r_baud == BAUD_MAX);
  assign w_cur_byte = r_sel ? r_byte1 : r_byte0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_sel   <= 1'b0;
      r_byte0 <= '0;
      r_byte1 <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_sel   <= w_sel_nxt;
      if (w_cap) begin
        r_byte0 <= result;
        r_byte1 <= {5'b00000, overflow, carry, zero};
      end
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
    end
  end

  // Outputs are computed from the next state so they register on the same
  // edge as the state change, keeping tx free of any input-to-pin path.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_sel_nxt   = r_sel;
    w_cap       = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (send) begin
          w_state_nxt = START;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_sel_nxt   = 1'b0;
          w_cap       = 1'b1;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end else begin
          w_baud_nxt  = r_baud + BW'(1);
        end
      end
      DATA: begin
        if (w_tick) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) w_state_nxt = STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      STOP: begin
        if (w_tick) begin
          w_baud_nxt = '0;
          if (!r_sel) begin
            w_sel_nxt   = 1'b1;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_tx_nxt = 1'b1;
    unique case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_cur_byte[w_bit_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: doc/alu_result_uart_tx.md
Name: alu_result_uart_tx

Overview:
- Output-side counterpart of the operand-loading path. Operands come in through the switch/button register bank; this block carries the ALU result and its flags back out.
- On a send request it snapshots the 8-bit ALU result and the zero/carry/overflow flags.
- It then serialises them as two 8N1 UART frames on a single tx line: the result byte first, then the flag byte.
- It sits after the ALU in the top level and drives one output pin. Its send strobe comes from the same debounced-button source used for operand loading.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Legal range is 2 or greater.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- send  input  1  request strobe; sampled every clk; level or pulse both accepted.
- result  input  8  ALU result Y.
- zero  input  1  ALU zero flag.
- carry  input  1  ALU carry flag.
- overflow  input  1  ALU overflow flag.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high while a two-byte transfer is in progress.
- done  output  1  one-cycle pulse at transfer completion.

Behaviour:
- Reset (rst_n low, asynchronous): tx=1, busy=0, done=0, state=IDLE, bit and byte counters cleared, capture registers cleared.
- Reset mid-transfer aborts immediately: tx returns high, and no done pulse is produced.
- Capture: when send=1 is sampled in IDLE, the block registers:
  - byte0 = result.
  - byte1 = {5'b00000, overflow, carry, zero}, so bit0 is zero and bit2 is overflow.
  - Inputs may change freely afterwards.
- send while busy=1 is ignored; there is no queueing.
- A level-held send re-triggers a new transfer on the first IDLE cycle.
- Latency: with send sampled at edge N, tx=0 and busy=1 from edge N+1.
- State machine (states IDLE, START, DATA, STOP; byte_sel 0/1):
  - IDLE: tx=1. On send, go to START with byte_sel=0.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx = current byte[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If byte_sel=0: set byte_sel=1 and go to START. There is no inter-frame gap.
    - If byte_sel=1: go to IDLE.
- Baud counter:
  - Counts 0 to CLKS_PER_BIT-1, then wraps to 0 and advances bit/state.
  - Cleared on every state entry from IDLE.
  - Sized $clog2(CLKS_PER_BIT).
- Total transfer time is exactly 20*CLKS_PER_BIT cycles from the first tx low to the return to IDLE.
- Completion:
  - On the edge leaving the final STOP: busy=0 and done=1 for exactly one cycle.
  - If send=1 in that done cycle, it is accepted: the next transfer starts at the following edge, with done and the new busy=1 non-overlapping.
- tx is driven from a register; no combinational path exists from any input to tx.
- busy is registered and equals (state != IDLE).

Test Plan (CLKS_PER_BIT=4 unless stated):
- Reset behaviour: hold rst_n=0 for 3 cycles, then release with send=0 → tx=1, busy=0, done=0 held indefinitely.
- Basic transfer:
  - Stimulus: result=8'hA5, zero=0, carry=1, overflow=0; 1-cycle send pulse.
  - tx sequence, sampled mid-bit every 4 cycles: 0,1,0,1,0,0,1,0,1,1 | 0,0,1,0,0,0,0,0,0,1.
  - busy high for 80 cycles; done pulses once, in the cycle busy falls.
- Capture isolation: send with result=8'h00, zero=1 (flag byte 8'h01), then change result to 8'hFF on the next cycle → transmitted bytes remain 8'h00 and 8'h01.
- Busy rejection: a second send pulse at cycle 30 of a transfer → no effect; exactly 20 bit-periods and a single done pulse.
- Back-to-back: send held high continuously → a second transfer's start bit begins 1 cycle after done. Frame length is unchanged and no glitch high/low occurs within frames.
- Mid-transfer abort: assert rst_n=0 during bit 3 of byte0 → tx=1 and busy=0 immediately (asynchronously), done never pulses. After release, a new send transfers normally.
- Minimum divisor: CLKS_PER_BIT=2, result=8'h80, overflow=1 → each bit is 2 cycles wide; bytes read back as 8'h80 and 8'h04.
